// File: rtl/ipm2l_hsstlp_apb_initiator.sv
// ipm2l_hsstlp_apb_initiator
// Turns a single-outstanding valid/ready command into one APB transfer
// towards the HSST configuration bridge. The transfer is aborted if the
// bridge does not complete within TIMEOUT_CYCLES extra ACCESS cycles.
// The response is held until the requester consumes it. A sticky
// interrupt flag mirrors pulses on p_cfg_int.
module ipm2l_hsstlp_apb_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        p_cfg_clk,
    input  logic        p_cfg_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        p_cfg_psel,
    output logic        p_cfg_enable,
    output logic        p_cfg_write,
    output logic [15:0] p_cfg_addr,
    output logic [7:0]  p_cfg_wdata,
    input  logic        p_cfg_ready,
    input  logic [7:0]  p_cfg_rdata,
    input  logic        p_cfg_int,
    output logic        int_pending,
    input  logic        int_clr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Wait counter limit; the legal range 1..255 fits the 8-bit counter.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        psel_q, psel_d;
    logic        enable_q, enable_d;
    logic        write_q, write_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        int_pending_q, int_pending_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    // Next state and next registered outputs of the transfer sequencer
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        psel_d        = psel_q;
        enable_d      = enable_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        wait_cnt_d    = wait_cnt_q;

        // A new interrupt pulse always beats a simultaneous clear.
        if (p_cfg_int) begin
            int_pending_d = 1'b1;
        end else if (int_clr) begin
            int_pending_d = 1'b0;
        end else begin
            int_pending_d = int_pending_q;
        end

        case (state_q)
            ST_IDLE: begin
                // req_ready rises one cycle after reset release, so only
                // accept once it is actually presented to the requester.
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = ST_SETUP;
                    req_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    enable_d    = 1'b0;
                    write_d     = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d     = ST_ACCESS;
                req_ready_d = 1'b0;
                psel_d      = 1'b1;
                enable_d    = 1'b1;
                wait_cnt_d  = 8'd0;
            end
            ST_ACCESS: begin
                req_ready_d = 1'b0;
                if (p_cfg_ready) begin
                    // Completion wins even on the cycle the limit is reached.
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = write_q ? 8'd0 : p_cfg_rdata;
                end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    enable_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 8'd0;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                    req_ready_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b0;
                psel_d      = 1'b0;
                enable_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge p_cfg_clk) begin
        if (p_cfg_rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            enable_q      <= 1'b0;
            write_q       <= 1'b0;
            addr_q        <= 16'd0;
            wdata_q       <= 8'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'd0;
            rsp_err_q     <= 1'b0;
            int_pending_q <= 1'b0;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            psel_q        <= psel_d;
            enable_q      <= enable_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            int_pending_q <= int_pending_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign p_cfg_psel   = psel_q;
    assign p_cfg_enable = enable_q;
    assign p_cfg_write  = write_q;
    assign p_cfg_addr   = addr_q;
    assign p_cfg_wdata  = wdata_q;
    assign int_pending  = int_pending_q;

endmodule

// File: tb/tb_ipm2l_hsstlp_apb_initiator.sv
// Testbench for ipm2l_hsstlp_apb_initiator: a driver issues commands and
// pushes the expected response into a queue; a monitor pops and compares
// whenever a response is presented; a bridge model answers APB transfers.
module tb_ipm2l_hsstlp_apb_initiator;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata;
    logic        pready;
    logic [7:0]  prdata;
    logic        pint, int_pending, int_clr;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks;
    int          failures;

    // Current transaction as seen by the bridge model
    logic        cur_wr;
    logic [15:0] cur_addr;
    logic [7:0]  cur_wdata;
    int          cur_waits;
    logic [7:0]  cur_rdata;
    bit          skip_len;

    ipm2l_hsstlp_apb_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .p_cfg_clk    (clk),
        .p_cfg_rst    (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .p_cfg_psel   (psel),
        .p_cfg_enable (penable),
        .p_cfg_write  (pwrite),
        .p_cfg_addr   (paddr),
        .p_cfg_wdata  (pwdata),
        .p_cfg_ready  (pready),
        .p_cfg_rdata  (prdata),
        .p_cfg_int    (pint),
        .int_pending  (int_pending),
        .int_clr      (int_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bridge model: answers on ACCESS cycle (waits+1), checks APB fields
    initial begin
        int k;
        int exp_len;
        k = 0;
        pready = 1'b0;
        prdata = 8'd0;
        forever begin
            @(negedge clk);
            if (psel === 1'b1 && penable === 1'b0) begin
                k = 0;
                chk("setup_addr", paddr, cur_addr);
                chk("setup_write", pwrite, cur_wr);
                chk("setup_wdata", pwdata, cur_wdata);
                pready = 1'($urandom);
                prdata = 8'($urandom);
            end else if (psel === 1'b1 && penable === 1'b1) begin
                k++;
                chk("access_addr", paddr, cur_addr);
                chk("access_write", pwrite, cur_wr);
                chk("access_wdata", pwdata, cur_wdata);
                pready = (k == cur_waits + 1);
                prdata = (k == cur_waits + 1) ? cur_rdata : 8'($urandom);
            end else begin
                if (k > 0) begin
                    exp_len = ((cur_waits < TO) ? cur_waits : TO) + 1;
                    if (!skip_len) chk("enable_cycles", k, exp_len);
                    k = 0;
                end
                if (rsp_valid === 1'b1 && !skip_len) chk("resp_addr_hold", paddr, cur_addr);
                pready = 1'($urandom);
                prdata = 8'($urandom);
            end
        end
    end

    // Response monitor: compares every presented response with the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rsp actual=rsp_valid=1 required=no_response at %0t", $time);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_err", rsp_err, exp_q[0].err);
                    if (rsp_ready === 1'b1) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Watchdog: the bench must always terminate
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                          input int waits, input logic [7:0] rd, input int hold, input bit poke);
        bit   ok;
        bit   got;
        int   n;
        int   m;
        rsp_t e;
        @(posedge clk);
        #1;
        cur_wr = wr; cur_addr = addr; cur_wdata = wd; cur_waits = waits; cur_rdata = rd;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", ok, 1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        e.err   = (waits > TO);
        e.rdata = (wr || e.err) ? 8'd0 : rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        m = (waits < TO) ? waits : TO;
        n = 0;
        got = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) chk("setup_no_ready", req_ready, 0);
            if (rsp_valid === 1'b1) begin
                n = i;
                got = 1'b1;
                break;
            end
        end
        chk("rsp_latency", n, 3 + m);
        if (!got) return;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (poke) req_valid = 1'b1;
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("busy_no_ready", req_ready, 0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_rsp_valid", rsp_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);
    endtask

    initial begin
        bit ok;
        checks = 0; failures = 0; skip_len = 1'b0;
        cur_wr = 1'b0; cur_addr = 16'd0; cur_wdata = 8'd0; cur_waits = 0; cur_rdata = 8'd0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'd0; req_wdata = 8'd0;
        rsp_ready = 1'b0; pint = 1'b0; int_clr = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_enable", penable, 0);
        chk("rst_write", pwrite, 0);
        chk("rst_addr", paddr, 0);
        chk("rst_wdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_int_pending", int_pending, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_req_ready", req_ready, 1);

        // Directed transfers
        do_txn(1'b1, 16'h4010, 8'h5A, 0, 8'h00, 0, 1'b0);
        do_txn(1'b0, 16'h1004, 8'h00, 3, 8'hC3, 0, 1'b0);
        do_txn(1'b0, 16'h3333, 8'h00, 10, 8'h77, 1, 1'b0);
        do_txn(1'b0, 16'h3334, 8'h00, TO, 8'h99, 0, 1'b0);
        do_txn(1'b1, 16'h3335, 8'h42, TO + 1, 8'h55, 0, 1'b0);
        do_txn(1'b0, 16'h5000, 8'hA5, 2, 8'h6E, 10, 1'b1);

        // Interrupt flag
        @(posedge clk); #1; pint = 1'b1;
        @(posedge clk); #1; pint = 1'b0;
        @(negedge clk);
        chk("int_set", int_pending, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("int_sticky", int_pending, 1);
        @(posedge clk); #1; pint = 1'b1; int_clr = 1'b1;
        @(posedge clk); #1; pint = 1'b0;
        @(negedge clk);
        chk("int_set_wins", int_pending, 1);
        @(posedge clk); #1; int_clr = 1'b0;
        @(negedge clk);
        chk("int_clr", int_pending, 0);

        // Reset in the middle of ACCESS
        cur_wr = 1'b0; cur_addr = 16'h2ABC; cur_wdata = 8'h00; cur_waits = 100; cur_rdata = 8'h00;
        skip_len = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h2ABC; req_wdata = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_txn_accept", ok, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_txn_access", {psel, penable}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_psel", psel, 0);
        chk("midrst_enable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_addr", paddr, 0);
        chk("midrst_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_ready", req_ready, 1);
        chk("midrst_no_rsp", rsp_valid, 0);
        skip_len = 1'b0;
        do_txn(1'b1, 16'h6001, 8'h3C, 1, 8'h00, 0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 30; t++) begin
            logic        wr;
            logic [15:0] ad;
            logic [7:0]  wd;
            logic [7:0]  rd;
            int          w;
            int          h;
            bit          pk;
            wr = 1'($urandom);
            ad = 16'($urandom);
            wd = 8'($urandom);
            rd = 8'($urandom);
            w  = int'($urandom_range(0, 7));
            h  = int'($urandom_range(0, 3));
            pk = 1'($urandom);
            do_txn(wr, ad, wd, w, rd, h, pk);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
